// File: rtl/matrix_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// matrix_pingpong_buffer
//
// Two-bank (ping-pong) DIM x DIM matrix operand buffer. One bank is filled
// from a row-major element stream while the other bank's complete matrix is
// held on a flat output bus for the multiplier array.
//
// Ports:
//   clk         system clock, all state changes on its rising edge
//   rst         asynchronous, active-high reset
//   wr_valid    input element valid
//   wr_ready    buffer can accept an element (bank being loaded not full)
//   wr_data     input element, row-major stream
//   clear       synchronous abort of the partially loaded bank
//   transpose   present the next matrix transposed (sampled on output load)
//   rd_valid    mat_data holds a complete matrix
//   rd_ready    consumer accepts mat_data
//   mat_data    matrix, element k = r*DIM+c at bits [k*DATA_W +: DATA_W]
//   bank_full   per-bank full flags
//   load_count  elements accepted into the bank currently loading
// ---------------------------------------------------------------------------
module matrix_pingpong_buffer #(
    parameter int DATA_W = 8,
    parameter int DIM    = 3,
    parameter int CNT_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       clear,
    input  logic                       transpose,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DIM*DIM*DATA_W-1:0]  mat_data,
    output logic [1:0]                 bank_full,
    output logic [CNT_W-1:0]           load_count
);

    localparam int                 N        = DIM * DIM;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(N - 1);

    typedef enum logic {
        ST_EMPTY   = 1'b0,
        ST_PRESENT = 1'b1
    } rd_state_t;

    // Bank storage: read in parallel as a whole matrix, so it lives in fabric
    // registers rather than a block RAM. Contents need no reset.
    logic [DATA_W-1:0] bank_mem [2][N];

    // Write-side state
    logic             wsel_q,       wsel_d;
    logic [CNT_W-1:0] load_count_q, load_count_d;
    logic [1:0]       bank_full_q,  bank_full_d;

    // Read-side FSM state and registered outputs
    rd_state_t             state_q;
    logic                  rsel_q;
    logic                  rd_valid_q;
    logic [N*DATA_W-1:0]   mat_data_q;

    // Candidate output images of the read bank
    logic [N*DATA_W-1:0]   mat_plain;
    logic [N*DATA_W-1:0]   mat_trans;
    logic [N*DATA_W-1:0]   mat_next;

    logic wr_accept;
    logic wr_last;
    logic rd_release;

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    assign wr_ready   = ~bank_full_q[wsel_q];
    assign wr_accept  = wr_valid & wr_ready & ~clear;   // clear drops the beat
    assign wr_last    = (load_count_q == LAST_IDX);
    assign rd_release = (state_q == ST_PRESENT) & rd_ready;

    // -----------------------------------------------------------------------
    // Write-side next state. Completion sets the flag of the loading bank and
    // release clears the flag of the presented bank; these can never target
    // the same bank on one edge (set needs it empty, release needs it full).
    // -----------------------------------------------------------------------
    always_comb begin
        bank_full_d  = bank_full_q;
        load_count_d = load_count_q;
        wsel_d       = wsel_q;

        if (wr_accept && wr_last) begin
            bank_full_d[wsel_q] = 1'b1;
        end
        if (rd_release) begin
            bank_full_d[rsel_q] = 1'b0;
        end

        if (clear) begin
            load_count_d = '0;
        end else if (wr_accept) begin
            if (wr_last) begin
                load_count_d = '0;
                wsel_d       = ~wsel_q;
            end else begin
                load_count_d = load_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wsel_q       <= 1'b0;
            load_count_q <= '0;
            bank_full_q  <= 2'b00;
        end else begin
            wsel_q       <= wsel_d;
            load_count_q <= load_count_d;
            bank_full_q  <= bank_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            bank_mem[wsel_q][load_count_q] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Output image: element k = r*DIM+c comes from stored k, or from stored
    // c*DIM+r when transposing.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_elem
            localparam int ROW = gi / DIM;
            localparam int COL = gi % DIM;
            assign mat_plain[gi*DATA_W +: DATA_W] = bank_mem[rsel_q][gi];
            assign mat_trans[gi*DATA_W +: DATA_W] = bank_mem[rsel_q][COL*DIM + ROW];
        end
    endgenerate

    assign mat_next = transpose ? mat_trans : mat_plain;

    // -----------------------------------------------------------------------
    // Read FSM. The output register loads one edge after the bank becomes
    // full, and is frozen while presented so transpose is ignored there.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rsel_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            mat_data_q <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (bank_full_q[rsel_q]) begin
                        mat_data_q <= mat_next;
                        rd_valid_q <= 1'b1;
                        state_q    <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (rd_ready) begin
                        rsel_q     <= ~rsel_q;
                        rd_valid_q <= 1'b0;
                        state_q    <= ST_EMPTY;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    rd_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_valid   = rd_valid_q;
    assign mat_data   = mat_data_q;
    assign bank_full  = bank_full_q;
    assign load_count = load_count_q;

endmodule

// File: tb/tb_matrix_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// tb_matrix_pingpong_buffer
//
// Directed bench for matrix_pingpong_buffer (DATA_W=8, DIM=3, CNT_W=4).
// Expected matrices are queued when a load is issued; a monitor pops and
// compares on every read handshake. Flags and counters are checked inline.
// ---------------------------------------------------------------------------
module tb_matrix_pingpong_buffer;

    localparam int DW  = 8;
    localparam int DIM = 3;
    localparam int CW  = 4;
    localparam int N   = DIM * DIM;

    logic              clk;
    logic              rst;
    logic              wr_valid;
    logic              wr_ready;
    logic [DW-1:0]     wr_data;
    logic              clear;
    logic              transpose;
    logic              rd_valid;
    logic              rd_ready;
    logic [N*DW-1:0]   mat_data;
    logic [1:0]        bank_full;
    logic [CW-1:0]     load_count;

    int vectors     = 0;
    int miscompares = 0;

    logic [N*DW-1:0] sb[$];

    matrix_pingpong_buffer #(
        .DATA_W (DW),
        .DIM    (DIM),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .clear      (clear),
        .transpose  (transpose),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .mat_data   (mat_data),
        .bank_full  (bank_full),
        .load_count (load_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix whose stored element k is base+k, optionally transposed.
    function automatic logic [N*DW-1:0] pack(input int base, input bit tr);
        logic [N*DW-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) begin
            int r;
            int c;
            r = k / DIM;
            c = k % DIM;
            m[k*DW +: DW] = DW'(tr ? (base + c*DIM + r) : (base + k));
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic timeout_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting, expected event within bound", name);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = DW'(d);
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        if (!wr_ready) timeout_fail("send");
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic wait_rd_valid;
        int n;
        n = 0;
        while (!rd_valid && n < 20) begin
            tick();
            n++;
        end
        if (!rd_valid) timeout_fail("wait_rd_valid");
    endtask

    task automatic wait_drain;
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        if (sb.size() != 0) timeout_fail("wait_drain");
    endtask

    // Monitor: a handshake completes on the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && rd_valid && rd_ready) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_matrix: got %0h expected none", mat_data);
                end else begin
                    logic [N*DW-1:0] exp;
                    exp = sb.pop_front();
                    check("matrix", mat_data, exp);
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = '0;
        clear     = 1'b0;
        transpose = 1'b0;
        rd_ready  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_mat_data",   mat_data, 0);
        check("rst_rd_valid",   rd_valid, 0);
        check("rst_bank_full",  bank_full, 0);
        check("rst_load_count", load_count, 0);
        check("rst_wr_ready",   wr_ready, 1);

        // Plain load 1..9
        sb.push_back(pack(1, 0));
        for (int i = 1; i <= 9; i++) begin
            send(i);
            check("load_count", load_count, i % 9);
        end
        check("load_bank_full", bank_full, 2'b01);
        check("load_rd_valid_t", rd_valid, 0);
        tick();
        check("load_rd_valid_t1", rd_valid, 1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("load_rd_valid_after", rd_valid, 0);
        check("load_bank_free", bank_full, 2'b00);

        // Transposed load; transpose dropped while presented must not matter
        transpose = 1'b1;
        sb.push_back(pack(1, 1));
        for (int i = 1; i <= 9; i++) send(i);
        wait_rd_valid();
        transpose = 1'b0;
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;

        // Backpressure: two matrices fill both banks, beat 19 stalls
        sb.push_back(pack(1, 0));
        sb.push_back(pack(10, 0));
        for (int i = 1; i <= 18; i++) send(i);
        check("bp_wr_ready", wr_ready, 0);
        check("bp_bank_full", bank_full, 2'b11);
        wr_valid = 1'b1;
        wr_data  = 8'd19;
        tick();
        tick();
        check("bp_held_count", load_count, 0);
        check("bp_held_ready", wr_ready, 0);
        rd_ready = 1'b1;
        tick();
        check("bp_release_ready", wr_ready, 1);
        check("bp_release_full", bank_full, 2'b10);
        check("bp_release_count", load_count, 0);
        tick();
        wr_valid = 1'b0;
        check("bp_beat19_count", load_count, 1);
        tick();
        check("bp_second_full", bank_full, 2'b00);
        check("bp_second_valid", rd_valid, 0);
        wait_drain();
        rd_ready = 1'b0;

        // clear: abort the lone beat 19, then 4 beats + clear with 5th
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_count0", load_count, 0);
        for (int i = 1; i <= 4; i++) send(i);
        check("clr_count4", load_count, 4);
        wr_valid = 1'b1;
        wr_data  = 8'd5;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        wr_valid = 1'b0;
        check("clr_drop_count", load_count, 0);
        check("clr_bank_full", bank_full, 2'b00);
        sb.push_back(pack(20, 0));
        for (int i = 20; i <= 28; i++) send(i);
        wait_rd_valid();
        rd_ready = 1'b1;
        wait_drain();
        rd_ready = 1'b0;
        tick();

        // Async reset mid-load with a matrix presented (never consumed)
        for (int i = 41; i <= 49; i++) send(i);
        wait_rd_valid();
        for (int i = 1; i <= 5; i++) send(i);
        check("ar_count_before", load_count, 5);
        check("ar_valid_before", rd_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("ar_rd_valid",   rd_valid, 0);
        check("ar_bank_full",  bank_full, 0);
        check("ar_load_count", load_count, 0);
        check("ar_mat_data",   mat_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.push_back(pack(1, 0));
        for (int i = 1; i <= 9; i++) send(i);
        wait_rd_valid();
        rd_ready = 1'b1;
        wait_drain();
        rd_ready = 1'b0;
        tick();

        check("sb_empty", sb.size(), 0);
        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
